dom_and_pipe: RTL and testbench

Pipelined, parametrised-order masked AND gadget in the domain-oriented masking (DOM) style: computes the shared AND of two Boolean-shared operands, NSHARES shares each, WIDTH bits per share, bit-sliced. It is the registered, glitch-resistant successor to the combinational 3-share ISW gadget. It sits inside masked S-box and datapath pipelines and is fed by the fresh-randomness source through its own handshake.

---
 rtl/dom_pkg.sv | 17 +
 rtl/pipe_stage.sv | 52 +++++
 rtl/dom_and_pipe.sv | 89 ++++++++
 tb/tb_dom_and_pipe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dom_pkg.sv
// Shared helpers for domain-oriented masking gadgets: randomness sizing and
// the mapping from an unordered share pair (i,j) to its random word index.
package dom_pkg;

    localparam int DOM_MIN_SHARES = 2;
    localparam int DOM_MAX_SHARES = 8;

    function automatic int nrand(input int n);
        return (n * (n - 1)) / 2;
    endfunction

    // Caller guarantees i < j; pairs are enumerated row by row.
    function automatic int pair_idx(input int i, input int j, input int n);
        return (i * n) - ((i * (i + 1)) / 2) + (j - i - 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/ready register stage: holds its data while the successor stalls,
// and loads a new word in the same cycle the current one drains.
module pipe_stage #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          valid_q;
    logic          valid_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Next-state: data only changes on an actual load, so a stalled word never moves.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready) begin
            valid_d = in_valid;
        end else begin
            valid_d = valid_q;
        end
        if (in_ready && in_valid) begin
            data_d = in_data;
        end else begin
            data_d = data_q;
        end
    end

    // Stage registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= {DW{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/dom_and_pipe.sv
// Two-stage DOM masked AND: stage 1 registers every inner and refreshed cross
// product separately, stage 2 compresses each share's row into its output share.
module dom_and_pipe
    import dom_pkg::*;
#(
    parameter  int NSHARES = 3,
    parameter  int WIDTH   = 1,
    localparam int NRAND   = nrand(NSHARES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NSHARES*WIDTH-1:0]   a,
    input  logic [NSHARES*WIDTH-1:0]   b,
    input  logic [NRAND*WIDTH-1:0]     rnd,
    input  logic                       rnd_valid,
    output logic                       rnd_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NSHARES*WIDTH-1:0]   c,
    output logic                       busy
);

    localparam int SW = NSHARES * WIDTH;
    localparam int XW = NSHARES * NSHARES * WIDTH;

    logic [XW-1:0] s1_in_s;
    logic [XW-1:0] s1_out_s;
    logic [SW-1:0] s2_in_s;
    logic          s1_valid_s;
    logic          s1_ready_s;
    logic          s2_ready_s;

    assign in_ready  = s1_ready_s;
    assign rnd_ready = in_valid && rnd_valid && s1_ready_s;
    assign busy      = s1_valid_s || out_valid;

    for (genvar i = 0; i < NSHARES; i++) begin : g_row
        logic [WIDTH-1:0] acc_s;

        // Slot (i,i) holds the inner product; every other slot holds one
        // refreshed cross term, kept in its own register before any mixing.
        for (genvar j = 0; j < NSHARES; j++) begin : g_col
            if (i == j) begin : g_inner
                assign s1_in_s[(i*NSHARES+j)*WIDTH +: WIDTH] =
                    a[i*WIDTH +: WIDTH] & b[i*WIDTH +: WIDTH];
            end else begin : g_cross
                localparam int K = (i < j) ? pair_idx(i, j, NSHARES)
                                           : pair_idx(j, i, NSHARES);
                assign s1_in_s[(i*NSHARES+j)*WIDTH +: WIDTH] =
                    (a[i*WIDTH +: WIDTH] & b[j*WIDTH +: WIDTH]) ^ rnd[K*WIDTH +: WIDTH];
            end
        end

        // Output share i: XOR of its registered row (inner plus all cross terms).
        always_comb begin
            acc_s = {WIDTH{1'b0}};
            for (int jj = 0; jj < NSHARES; jj++) begin
                acc_s = acc_s ^ s1_out_s[(i*NSHARES+jj)*WIDTH +: WIDTH];
            end
        end

        assign s2_in_s[i*WIDTH +: WIDTH] = acc_s;
    end

    pipe_stage #(.DW(XW)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid && rnd_valid),
        .in_ready  (s1_ready_s),
        .in_data   (s1_in_s),
        .out_valid (s1_valid_s),
        .out_ready (s2_ready_s),
        .out_data  (s1_out_s)
    );

    pipe_stage #(.DW(SW)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid_s),
        .in_ready  (s2_ready_s),
        .in_data   (s2_in_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (c)
    );

endmodule

// File: tb/tb_dom_and_pipe.sv
// Self-checking bench for dom_and_pipe: directed 3-share example, random
// 4-share stream with stalls and reset, and a 2-share stream.
module tb_dom_and_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 4 shares x 8 lanes (NRAND = 6)
    logic        m_in_valid, m_in_ready, m_rnd_valid, m_rnd_ready;
    logic        m_out_valid, m_out_ready, m_busy;
    logic [31:0] m_a, m_b, m_c;
    logic [47:0] m_rnd;
    // 3 shares x 1 lane (NRAND = 3)
    logic        t_in_valid, t_in_ready, t_rnd_valid, t_rnd_ready;
    logic        t_out_valid, t_out_ready, t_busy;
    logic [2:0]  t_a, t_b, t_c, t_rnd;
    // 2 shares x 4 lanes (NRAND = 1)
    logic        d_in_valid, d_in_ready, d_rnd_valid, d_rnd_ready;
    logic        d_out_valid, d_out_ready, d_busy;
    logic [7:0]  d_a, d_b, d_c;
    logic [3:0]  d_rnd;

    dom_and_pipe #(.NSHARES(4), .WIDTH(8)) u_m (
        .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .a(m_a), .b(m_b), .rnd(m_rnd), .rnd_valid(m_rnd_valid), .rnd_ready(m_rnd_ready),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .c(m_c), .busy(m_busy));

    dom_and_pipe #(.NSHARES(3), .WIDTH(1)) u_t (
        .clk(clk), .rst(rst), .in_valid(t_in_valid), .in_ready(t_in_ready),
        .a(t_a), .b(t_b), .rnd(t_rnd), .rnd_valid(t_rnd_valid), .rnd_ready(t_rnd_ready),
        .out_valid(t_out_valid), .out_ready(t_out_ready), .c(t_c), .busy(t_busy));

    dom_and_pipe #(.NSHARES(2), .WIDTH(4)) u_d (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .a(d_a), .b(d_b), .rnd(d_rnd), .rnd_valid(d_rnd_valid), .rnd_ready(d_rnd_ready),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .c(d_c), .busy(d_busy));

    int total = 0;
    int bad   = 0;

    // Reference for the 4-share instance: two occupancy slots holding expected results.
    bit          mv1, mv2;
    logic [63:0] mc1, mc2, mx1, mx2;
    int          acc_cnt, del_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] lane_mask(input int w);
        return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    // XOR of all shares: the unmasked value of a shared operand.
    function automatic logic [63:0] xsh(input int n, input int w, input logic [63:0] v);
        logic [63:0] res;
        res = 64'd0;
        for (int i = 0; i < n; i++) res = res ^ ((v >> (i * w)) & lane_mask(w));
        return res;
    endfunction

    // Expected shares: c_i = a_i&b_i ^ XOR_{j!=i} (a_i&b_j ^ r_{ij}), pairs numbered i<j row by row.
    function automatic logic [63:0] exp_c(input int n, input int w, input logic [63:0] a,
                                          input logic [63:0] b, input logic [63:0] r);
        logic [63:0] rr [0:7][0:7];
        logic [63:0] res, ai, s, mask;
        int k;
        mask = lane_mask(w);
        k = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) rr[i][j] = 64'd0;
        for (int i = 0; i < n; i++)
            for (int j = i + 1; j < n; j++) begin
                rr[i][j] = (r >> (k * w)) & mask;
                rr[j][i] = rr[i][j];
                k++;
            end
        res = 64'd0;
        for (int i = 0; i < n; i++) begin
            ai = (a >> (i * w)) & mask;
            s  = ai & ((b >> (i * w)) & mask);
            for (int j = 0; j < n; j++)
                if (j != i) s = s ^ (ai & ((b >> (j * w)) & mask)) ^ rr[i][j];
            res = res | (s << (i * w));
        end
        return res;
    endfunction

    // One clock of the 4-share instance with inputs already driven.
    task automatic mcyc();
        logic        exp_ir, fire, adv2;
        logic [63:0] newc, newx;
        #1;
        exp_ir = !mv1 || !mv2 || m_out_ready;
        fire   = m_in_valid && m_rnd_valid && exp_ir;
        chk("m_in_ready", 64'(m_in_ready), 64'(exp_ir));
        chk("m_rnd_ready", 64'(m_rnd_ready), 64'(fire));
        newc = exp_c(4, 8, 64'(m_a), 64'(m_b), 64'(m_rnd));
        newx = xsh(4, 8, 64'(m_a)) & xsh(4, 8, 64'(m_b));
        @(posedge clk);
        adv2 = !mv2 || m_out_ready;
        if (mv2 && m_out_ready) del_cnt++;
        if (adv2) begin
            mv2 = mv1; mc2 = mc1; mx2 = mx1;
        end
        if (exp_ir) begin
            mv1 = fire; mc1 = newc; mx1 = newx;
        end
        if (fire) acc_cnt++;
        #1;
        chk("m_out_valid", 64'(m_out_valid), 64'(mv2));
        chk("m_busy", 64'(m_busy), 64'(mv1 || mv2));
        if (mv2) begin
            chk("m_c", 64'(m_c), mc2);
            chk("m_xor_prop", xsh(4, 8, 64'(m_c)), mx2);
        end
    endtask

    task automatic mrand();
        m_a   = $urandom();
        m_b   = $urandom();
        m_rnd = {16'($urandom()), 32'($urandom())};
    endtask

    bit          pv0, pv1;
    logic [63:0] pc0, pc1, px0, px1, e;
    int          acc0;

    initial begin
        rst = 1'b1;
        m_in_valid = 1'b0; m_rnd_valid = 1'b0; m_out_ready = 1'b1;
        m_a = 32'd0; m_b = 32'd0; m_rnd = 48'd0;
        t_in_valid = 1'b0; t_rnd_valid = 1'b0; t_out_ready = 1'b1;
        t_a = 3'd0; t_b = 3'd0; t_rnd = 3'd0;
        d_in_valid = 1'b0; d_rnd_valid = 1'b0; d_out_ready = 1'b1;
        d_a = 8'd0; d_b = 8'd0; d_rnd = 4'd0;
        mv1 = 1'b0; mv2 = 1'b0; mc1 = 64'd0; mc2 = 64'd0; mx1 = 64'd0; mx2 = 64'd0;
        acc_cnt = 0; del_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(m_out_valid), 64'd0);
        chk("rst_busy", 64'(m_busy), 64'd0);
        chk("rst_c", 64'(m_c), 64'd0);
        chk("rst_in_ready", 64'(m_in_ready), 64'd1);
        rst = 1'b0;

        // Directed 3-share example: c = 011, two cycles after transfer.
        t_a = 3'b011; t_b = 3'b101; t_rnd = 3'b110; t_in_valid = 1'b1; t_rnd_valid = 1'b1;
        #1;
        chk("t_rnd_ready", 64'(t_rnd_ready), 64'd1);
        @(posedge clk); #1;
        t_in_valid = 1'b0; t_rnd_valid = 1'b0;
        chk("t_lat1_out_valid", 64'(t_out_valid), 64'd0);
        chk("t_lat1_busy", 64'(t_busy), 64'd1);
        @(posedge clk); #1;
        chk("t_lat2_out_valid", 64'(t_out_valid), 64'd1);
        chk("t_c_directed", 64'(t_c), 64'b011);
        chk("t_c_model", 64'(t_c), exp_c(3, 1, 64'b011, 64'b101, 64'b110));
        @(posedge clk); #1;
        chk("t_drained_out_valid", 64'(t_out_valid), 64'd0);
        chk("t_drained_busy", 64'(t_busy), 64'd0);

        // 1000 back-to-back random ops on 4 shares x 8 lanes.
        m_in_valid = 1'b1; m_rnd_valid = 1'b1; m_out_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            mrand();
            mcyc();
        end
        chk("m_stream_accepted", 64'(acc_cnt), 64'd1000);
        m_in_valid = 1'b0;
        mcyc(); mcyc(); mcyc();
        chk("m_stream_delivered", 64'(del_cnt), 64'd1000);

        // Downstream stall for 5 cycles with ops offered every cycle.
        acc0 = acc_cnt;
        m_out_ready = 1'b0; m_in_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            if (n < 3) mrand();
            mcyc();
        end
        chk("m_stall_accepted", 64'(acc_cnt - acc0), 64'd2);
        m_out_ready = 1'b1;
        mcyc();
        m_in_valid = 1'b0;
        for (int n = 0; n < 4; n++) mcyc();
        chk("m_stall_drained", 64'(m_busy), 64'd0);

        // Randomness starved for 3 cycles while an op drains.
        mrand(); m_in_valid = 1'b1; m_rnd_valid = 1'b1;
        mcyc();
        acc0 = acc_cnt;
        m_rnd_valid = 1'b0;
        for (int n = 0; n < 3; n++) begin
            mrand();
            mcyc();
        end
        chk("m_norand_accepted", 64'(acc_cnt - acc0), 64'd0);
        m_rnd_valid = 1'b1;
        mcyc();
        m_in_valid = 1'b0;
        mcyc(); mcyc(); mcyc();

        // Asynchronous reset between edges with both stages full.
        m_out_ready = 1'b0; m_in_valid = 1'b1;
        mrand(); mcyc();
        mrand(); mcyc();
        chk("m_full_busy", 64'(mv1 && mv2), 64'd1);
        m_in_valid = 1'b0;
        #2; rst = 1'b1; #1;
        chk("m_async_out_valid", 64'(m_out_valid), 64'd0);
        chk("m_async_busy", 64'(m_busy), 64'd0);
        chk("m_async_c", 64'(m_c), 64'd0);
        mv1 = 1'b0; mv2 = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0; #1;
        chk("m_post_rst_in_ready", 64'(m_in_ready), 64'd1);
        m_out_ready = 1'b1;
        mrand(); m_in_valid = 1'b1;
        mcyc();
        m_in_valid = 1'b0;
        mcyc(); mcyc();

        // 2-share stream: single pair word rnd[3:0].
        pv0 = 1'b0; pv1 = 1'b0; pc0 = 64'd0; pc1 = 64'd0; px0 = 64'd0; px1 = 64'd0;
        d_rnd_valid = 1'b1;
        for (int n = 0; n < 22; n++) begin
            d_in_valid = (n < 20);
            d_a = 8'($urandom()); d_b = 8'($urandom()); d_rnd = 4'($urandom());
            #1;
            chk("d_in_ready", 64'(d_in_ready), 64'd1);
            e = exp_c(2, 4, 64'(d_a), 64'(d_b), 64'(d_rnd));
            @(posedge clk); #1;
            pv1 = pv0; pc1 = pc0; px1 = px0;
            pv0 = d_in_valid; pc0 = e;
            px0 = xsh(2, 4, 64'(d_a)) & xsh(2, 4, 64'(d_b));
            chk("d_out_valid", 64'(d_out_valid), 64'(pv1));
            if (pv1) begin
                chk("d_c", 64'(d_c), pc1);
                chk("d_xor_prop", xsh(2, 4, 64'(d_c)), px1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
